// File: rtl/file1_pkg.sv
// -----------------------------------------------------------------------------
// file1_pkg
// Shared types and helpers for the file1 bit-lane arithmetic cell.
//
// Contents:
//   op_e      - operation select encoding used on the 2-bit op port
//   full_add  - single-bit full adder returning {carry, sum}
// -----------------------------------------------------------------------------
package file1_pkg;

    // Operation encoding carried on the op port.
    typedef enum logic [1:0] {
        OP_FADD  = 2'b00,  // per-lane full add
        OP_FSUB  = 2'b01,  // per-lane full subtract (a - b - c)
        OP_RADD  = 2'b10,  // WIDTH-bit ripple add, carry-in from c[0]
        OP_LOGIC = 2'b11   // per-lane AND / OR of the three inputs
    } op_e;

    // Number of operation codes; handy for stimulus generation and checks.
    localparam int OP_COUNT = 4;

    // Single-bit full adder. Result is packed as {carry, sum} so callers can
    // slice [1] for the carry and [0] for the sum.
    function automatic logic [1:0] full_add(
        input logic i_a,
        input logic i_b,
        input logic i_c
    );
        logic w_sum;
        logic w_carry;
        w_sum   = i_a ^ i_b ^ i_c;
        w_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
        return {w_carry, w_sum};
    endfunction

endpackage

// File: rtl/file1_lane.sv
// -----------------------------------------------------------------------------
// file1_lane
// One purely combinational bit lane of the file1 cell. Implements the
// lane-local operations: full add, full subtract and three-input logic.
// The ripple add needs carries between lanes, so it is built in file1_core;
// for that code this lane falls back to the full-add result, which is also
// exactly what a one-lane ripple add produces.
//
// Ports:
//   i_op  [1:0]  operation select (op_e encoding)
//   i_a          operand A bit
//   i_b          operand B bit
//   i_c          operand C bit (carry / borrow in)
//   o_d          result bit
//   o_e          carry / borrow / OR bit
// -----------------------------------------------------------------------------
module file1_lane
    import file1_pkg::*;
(
    input  logic [1:0] i_op,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    output logic       o_d,
    output logic       o_e
);

    logic [1:0] w_fadd;
    logic [1:0] w_fsub;

    assign w_fadd = full_add(i_a, i_b, i_c);

    // The borrow of a - b - c is the majority of (~a, b, c), so the same
    // full adder with A inverted yields it in the carry position.
    assign w_fsub = full_add(~i_a, i_b, i_c);

    always_comb begin
        o_d = w_fadd[0];
        o_e = w_fadd[1];
        case (op_e'(i_op))
            OP_FSUB: begin
                o_d = w_fadd[0];        // difference bit equals the sum bit
                o_e = w_fsub[1];
            end
            OP_LOGIC: begin
                o_d = i_a & i_b & i_c;
                o_e = i_a | i_b | i_c;
            end
            default: begin
                o_d = w_fadd[0];
                o_e = w_fadd[1];
            end
        endcase
    end

endmodule

// File: rtl/file1_core.sv
// -----------------------------------------------------------------------------
// file1_core
// Registered three-input bitwise arithmetic cell with a one-cycle pipeline
// and a valid qualifier. With the default WIDTH=1 it is a classic full adder
// (d = sum, e = carry).
//
// Parameters:
//   WIDTH        number of independent bit lanes (1..64)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     a/b/c/op are sampled this cycle
//   op  [1:0]    operation select (op_e encoding)
//   a   [W-1:0]  operand A lanes
//   b   [W-1:0]  operand B lanes
//   c   [W-1:0]  operand C lanes (carry / borrow in per lane)
//   out_valid    d/e hold a fresh result
//   d   [W-1:0]  result bits
//   e   [W-1:0]  carry / borrow bits
//   carry_cnt [31:0]  (only with FILE1_CORE_STATS_EN) saturating count of
//                sampled transactions whose result e is nonzero
//
// Build option:
//   FILE1_CORE_STATS_EN  adds the carry_cnt output and its counter.
// -----------------------------------------------------------------------------
module file1_core
    import file1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e
`ifdef FILE1_CORE_STATS_EN
    ,
    output logic [31:0]      carry_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Lane-local operations (add, subtract, logic)
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] w_lane_d;
    logic [WIDTH-1:0] w_lane_e;

    // -------------------------------------------------------------------------
    // Ripple adder: w_rc[i] is the carry into bit i, w_rc[WIDTH] the carry out
    // of the MSB. Only c[0] enters the chain; upper c bits are ignored here.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   w_rc;
    logic [WIDTH-1:0] w_rsum;

    assign w_rc[0] = c[0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic [1:0] w_fa;

            file1_lane u_lane (
                .i_op (op),
                .i_a  (a[gi]),
                .i_b  (b[gi]),
                .i_c  (c[gi]),
                .o_d  (w_lane_d[gi]),
                .o_e  (w_lane_e[gi])
            );

            assign w_fa         = full_add(a[gi], b[gi], w_rc[gi]);
            assign w_rsum[gi]   = w_fa[0];
            assign w_rc[gi + 1] = w_fa[1];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Result select. Every op code maps to a defined value, so an unused
    // path can never leak X into the registers.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] w_d_next;
    logic [WIDTH-1:0] w_e_next;

    always_comb begin
        w_d_next = w_lane_d;
        w_e_next = w_lane_e;
        if (op_e'(op) == OP_RADD) begin
            w_d_next    = w_rsum;
            w_e_next    = '0;
            w_e_next[0] = w_rc[WIDTH];
        end
    end

    // -------------------------------------------------------------------------
    // Output registers. d/e load only on a valid sample, so they hold their
    // last value while idle; out_valid simply follows in_valid by one cycle.
    // -------------------------------------------------------------------------
    logic             r_valid;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_e;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            r_e     <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_d <= w_d_next;
                r_e <= w_e_next;
            end
        end
    end

    assign out_valid = r_valid;
    assign d         = r_d;
    assign e         = r_e;

`ifdef FILE1_CORE_STATS_EN
    // -------------------------------------------------------------------------
    // Carry statistics. The count advances on the same edge that registers
    // the nonzero e, so carry_cnt and e stay aligned. Stops at all-ones.
    // -------------------------------------------------------------------------
    logic [31:0] r_carry_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry_cnt <= '0;
        end else if (in_valid && (|w_e_next) && (r_carry_cnt != 32'hFFFF_FFFF)) begin
            r_carry_cnt <= r_carry_cnt + 32'd1;
        end
    end

    assign carry_cnt = r_carry_cnt;
`endif

endmodule

// File: tb/tb_file1_core.sv
// -----------------------------------------------------------------------------
// tb_file1_core
// Self-checking bench for file1_core. Two instances run side by side: a
// WIDTH=1 cell and a WIDTH=4 cell. A reference model built from plain
// integer arithmetic predicts every output on every cycle; table entries and
// hand-written sequences additionally pin known results.
// -----------------------------------------------------------------------------
module tb_file1_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // WIDTH=1 instance signals
    logic       v1 = 1'b0;
    logic [1:0] op1 = 2'b00;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       ov1;
    logic       d1, e1;

    // WIDTH=4 instance signals
    logic       v4 = 1'b0;
    logic [1:0] op4 = 2'b00;
    logic [3:0] a4 = '0, b4 = '0, c4 = '0;
    logic       ov4;
    logic [3:0] d4, e4;

`ifdef FILE1_CORE_STATS_EN
    logic [31:0] cnt1, cnt4;
`endif

    file1_core #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .op        (op1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .out_valid (ov1),
        .d         (d1),
        .e         (e1)
`ifdef FILE1_CORE_STATS_EN
        ,
        .carry_cnt (cnt1)
`endif
    );

    file1_core #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4),
        .op        (op4),
        .a         (a4),
        .b         (b4),
        .c         (c4),
        .out_valid (ov4),
        .d         (d4),
        .e         (e4)
`ifdef FILE1_CORE_STATS_EN
        ,
        .carry_cnt (cnt4)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    logic       m_v1 = 1'b0, m_v4 = 1'b0;
    logic [3:0] m_d1 = '0, m_e1 = '0, m_d4 = '0, m_e4 = '0;
    longint     m_cnt1 = 0, m_cnt4 = 0;

    // Behavioural reference: lanes computed with integer arithmetic.
    function automatic void ref_model(
        input  int         w,
        input  logic [1:0] op,
        input  logic [3:0] a,
        input  logic [3:0] b,
        input  logic [3:0] c,
        output logic [3:0] d,
        output logic [3:0] e
    );
        d = '0;
        e = '0;
        if (op == 2'd2) begin
            int mask;
            int s;
            mask = (1 << w) - 1;
            s    = (int'(a) & mask) + (int'(b) & mask) + int'(c[0]);
            d    = 4'(s & mask);
            e    = 4'(s >> w);
        end else begin
            for (int i = 0; i < w; i++) begin
                int ai, bi, ci, s;
                ai = int'(a[i]);
                bi = int'(b[i]);
                ci = int'(c[i]);
                case (op)
                    2'd0: begin
                        s    = ai + bi + ci;
                        d[i] = (s % 2) == 1;
                        e[i] = s >= 2;
                    end
                    2'd1: begin
                        s    = ai - bi - ci;
                        d[i] = (s & 1) != 0;
                        e[i] = s < 0;
                    end
                    default: begin
                        d[i] = (ai + bi + ci) == 3;
                        e[i] = (ai + bi + ci) != 0;
                    end
                endcase
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Advance one clock, update the model from the sampled inputs and compare
    // every DUT output one time unit after the edge.
    task automatic tick(input string tag);
        logic [3:0] rd, re;
        @(posedge clk);
        if (!rst_n) begin
            m_v1 = 1'b0; m_d1 = '0; m_e1 = '0; m_cnt1 = 0;
            m_v4 = 1'b0; m_d4 = '0; m_e4 = '0; m_cnt4 = 0;
        end else begin
            m_v1 = v1;
            if (v1) begin
                ref_model(1, op1, {3'b000, a1}, {3'b000, b1}, {3'b000, c1}, rd, re);
                m_d1 = rd;
                m_e1 = re;
                if (re != 0 && m_cnt1 < 64'hFFFF_FFFF) m_cnt1++;
            end
            m_v4 = v4;
            if (v4) begin
                ref_model(4, op4, a4, b4, c4, rd, re);
                m_d4 = rd;
                m_e4 = re;
                if (re != 0 && m_cnt4 < 64'hFFFF_FFFF) m_cnt4++;
            end
        end
        #1;
        chk({tag, " u1.out_valid"}, 32'(ov1), 32'(m_v1));
        chk({tag, " u1.d"},         32'(d1),  32'(m_d1[0]));
        chk({tag, " u1.e"},         32'(e1),  32'(m_e1[0]));
        chk({tag, " u4.out_valid"}, 32'(ov4), 32'(m_v4));
        chk({tag, " u4.d"},         32'(d4),  32'(m_d4));
        chk({tag, " u4.e"},         32'(e4),  32'(m_e4));
`ifdef FILE1_CORE_STATS_EN
        chk({tag, " u1.carry_cnt"}, cnt1, 32'(m_cnt1));
        chk({tag, " u4.carry_cnt"}, cnt4, 32'(m_cnt4));
`endif
        $display("%s: rst_n=%b | u1 op=%0d abc=%b%b%b -> v=%b d=%b e=%b | u4 op=%0d a=%h b=%h c=%h -> v=%b d=%h e=%h",
                 tag, rst_n, op1, a1, b1, c1, ov1, d1, e1, op4, a4, b4, c4, ov4, d4, e4);
    endtask

    typedef struct {
        logic [1:0] op;
        logic       a, b, c;
        logic       d, e;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Truth table, full add: expected {d,e} 00,10,10,01,10,01,01,11
        tbl[0]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        // Full subtract
        tbl[8]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // ---- Reset wins over in_valid ----
        @(negedge clk);
        rst_n = 1'b0;
        v1 = 1'b1; op1 = 2'd0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        v4 = 1'b1; op4 = 2'd0; a4 = 4'hF; b4 = 4'hF; c4 = 4'hF;
        tick("reset0");
        tick("reset1");
        chk("reset u1.out_valid", 32'(ov1), 32'd0);
        chk("reset u1.d",         32'(d1),  32'd0);
        chk("reset u1.e",         32'(e1),  32'd0);
        chk("reset u4.out_valid", 32'(ov4), 32'd0);
        chk("reset u4.d",         32'(d4),  32'd0);
        chk("reset u4.e",         32'(e4),  32'd0);

        // ---- First result one cycle after reset release ----
        @(negedge clk);
        rst_n = 1'b1;
        v1 = 1'b1; op1 = 2'd0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
        v4 = 1'b0;
        tick("release");
        chk("release u1.out_valid", 32'(ov1), 32'd1);
        chk("release u1.d",         32'(d1),  32'd1);
        chk("release u1.e",         32'(e1),  32'd0);

        // ---- Table: truth table and subtract (WIDTH=1), back to back ----
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            v1 = 1'b1; op1 = tbl[i].op; a1 = tbl[i].a; b1 = tbl[i].b; c1 = tbl[i].c;
            tick($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d out_valid", i), 32'(ov1), 32'd1);
            chk($sformatf("tbl%0d d", i),         32'(d1),  32'(tbl[i].d));
            chk($sformatf("tbl%0d e", i),         32'(e1),  32'(tbl[i].e));
`ifdef FILE1_CORE_STATS_EN
            if (i == 7) chk("stats sweep carry_cnt", cnt1, 32'd4);
`endif
        end

        // ---- Hold: in_valid 1,0,0 with a=b=c=1 ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v1 = (i == 0); op1 = 2'd0;
            a1 = (i == 0); b1 = 1'b1; c1 = 1'b1;
            tick($sformatf("hold%0d", i));
            chk($sformatf("hold%0d out_valid", i), 32'(ov1), 32'(i == 0));
            chk($sformatf("hold%0d d", i),         32'(d1),  32'd1);
            chk($sformatf("hold%0d e", i),         32'(e1),  32'd1);
        end

        // ---- Ripple add, WIDTH=4 ----
        @(negedge clk);
        v1 = 1'b0;
        v4 = 1'b1; op4 = 2'd2; a4 = 4'hF; b4 = 4'h1; c4 = 4'h0;
        tick("radd0");
        chk("radd0 d", 32'(d4), 32'h0);
        chk("radd0 e", 32'(e4), 32'h1);
        @(negedge clk);
        a4 = 4'h3; b4 = 4'h4; c4 = 4'h1;
        tick("radd1");
        chk("radd1 d", 32'(d4), 32'h8);
        chk("radd1 e", 32'(e4), 32'h0);
        // Upper c bits must not influence the ripple sum.
        @(negedge clk);
        a4 = 4'h5; b4 = 4'h9; c4 = 4'hE;
        tick("radd2");
        chk("radd2 d", 32'(d4), 32'hE);
        chk("radd2 e", 32'(e4), 32'h0);

        // ---- Randomized traffic on both instances ----
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 39) != 0);
            v1  = 1'($urandom_range(0, 3) != 0);
            op1 = 2'($urandom_range(0, 3));
            a1  = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            v4  = 1'($urandom_range(0, 3) != 0);
            op4 = 2'($urandom_range(0, 3));
            a4  = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
            tick($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
